fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined CPU. Owns the architectural fetch PC and drives it to `branch_predictor`. Consumes the predicted `next_PC` returned by the predictor and issues instruction-memory reads through a ready handshake. Fills the IF/ID pipeline register, with a one-entry skid buffer for decode stalls and redirect-on-flush from the branch-resolve stage.

---
 rtl/fetch_stage_pkg.sv | 12 +
 rtl/ifid_skid_buffer.sv | 47 ++++
 rtl/fetch_stage.sv | 160 ++++++++++++++++
 tb/tb_fetch_stage.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared constants for the instruction-fetch stage
//
// Purpose : default datapath width (mirrors the shared opcodes header value)
//           and default reset PC used by fetch_stage and its IF/ID skid buffer.
// Ports   : none (package).

package fetch_stage_pkg;

   localparam int DEF_WORD_SIZE = 16;
   localparam logic [DEF_WORD_SIZE-1:0] DEF_RESET_PC = '0;

endpackage

// File: rtl/ifid_skid_buffer.sv
// rtl/ifid_skid_buffer.sv - one-entry {instr, PC, pred_PC} skid store for IF/ID
//
// Purpose : holds one fetched instruction that arrived while decode was
//           stalled, so the memory response is never lost.
// Ports   : clk, reset_n      - clock, async active-low reset
//           load              - capture load_* into the entry, mark valid
//           drop              - empty the entry (flush or move into IF/ID)
//           load_instr/pc/pred_pc - incoming entry fields
//           instr/pc/pred_pc  - stored entry fields
//           valid             - entry holds a live instruction

module ifid_skid_buffer
   import fetch_stage_pkg::*;
#(
   parameter int WIDTH = DEF_WORD_SIZE
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic             drop,
   input  logic [WIDTH-1:0] load_instr,
   input  logic [WIDTH-1:0] load_pc,
   input  logic [WIDTH-1:0] load_pred_pc,
   output logic [WIDTH-1:0] instr,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pred_pc,
   output logic             valid
);

   // Drop has priority so a flush can never leave a stale entry behind.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         instr   <= '0;
         pc      <= '0;
         pred_pc <= '0;
         valid   <= 1'b0;
      end else if (drop) begin
         valid   <= 1'b0;
      end else if (load) begin
         instr   <= load_instr;
         pc      <= load_pc;
         pred_pc <= load_pred_pc;
         valid   <= 1'b1;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction-fetch stage: fetch PC, memory request, IF/ID register
//
// Purpose : owns the fetch PC, follows the predictor's next_PC, issues
//           instruction-memory reads and fills IF/ID, with a one-entry skid
//           buffer for decode stalls and redirect on flush.
// Ports   : clk, reset_n         - clock, async active-low reset
//           PC / pred_next_PC    - fetch PC to predictor / predicted successor
//           flush, flush_PC      - redirect from branch resolve
//           stall                - decode cannot take IF/ID this cycle
//           i_readM, i_address   - memory read request and address (= PC)
//           i_data, i_ready      - memory response
//           ifid_instr/PC/pred_PC/valid - IF/ID pipeline register
//           fetch_count          - IF/ID loads since reset (wraps)

module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter int                  WORD_SIZE = DEF_WORD_SIZE,
   parameter logic [WORD_SIZE-1:0] RESET_PC = DEF_RESET_PC
) (
   input  logic                 clk,
   input  logic                 reset_n,
   output logic [WORD_SIZE-1:0] PC,
   input  logic [WORD_SIZE-1:0] pred_next_PC,
   input  logic                 flush,
   input  logic [WORD_SIZE-1:0] flush_PC,
   input  logic                 stall,
   output logic                 i_readM,
   output logic [WORD_SIZE-1:0] i_address,
   input  logic [WORD_SIZE-1:0] i_data,
   input  logic                 i_ready,
   output logic [WORD_SIZE-1:0] ifid_instr,
   output logic [WORD_SIZE-1:0] ifid_PC,
   output logic [WORD_SIZE-1:0] ifid_pred_PC,
   output logic                 ifid_valid,
   output logic [WORD_SIZE-1:0] fetch_count
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   state_t state;
   state_t state_next;

   logic                 decode_accepts;
   logic                 flush_act;
   logic                 load_mem;
   logic                 load_skid;
   logic                 load_from_skid;
   logic                 clear_valid;

   logic [WORD_SIZE-1:0] skid_instr;
   logic [WORD_SIZE-1:0] skid_pc;
   logic [WORD_SIZE-1:0] skid_pred_pc;
   logic                 skid_valid;

   // An empty IF/ID can always be overwritten, even under stall.
   assign decode_accepts = !stall || !ifid_valid;

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; flush redirects to FETCH from any non-idle state
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  state_next = S_FETCH;
         S_FETCH: begin
            if (flush)
               state_next = S_FETCH;
            else if (i_ready && !decode_accepts)
               state_next = S_HOLD;
            else
               state_next = S_FETCH;
         end
         S_HOLD: begin
            if (flush || !stall)
               state_next = S_FETCH;
            else
               state_next = S_HOLD;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Output / control decode
   always_comb begin
      i_readM        = (state == S_FETCH);
      flush_act      = flush && (state != S_IDLE);
      load_mem       = (state == S_FETCH) && i_ready && !flush && decode_accepts;
      load_skid      = (state == S_FETCH) && i_ready && !flush && !decode_accepts;
      load_from_skid = (state == S_HOLD) && !flush && !stall && skid_valid;
      // A waiting fetch with decode free means IF/ID was just consumed: bubble.
      clear_valid    = flush_act || ((state == S_FETCH) && !i_ready && !stall);
   end

   assign i_address = PC;

   // Fetch PC: flush value wins, otherwise advance on any captured response
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         PC <= RESET_PC;
      end else if (flush_act) begin
         PC <= flush_PC;
      end else if (load_mem || load_skid) begin
         PC <= pred_next_PC;
      end
   end

   // IF/ID register and load counter
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ifid_instr   <= '0;
         ifid_PC      <= '0;
         ifid_pred_PC <= '0;
         ifid_valid   <= 1'b0;
         fetch_count  <= '0;
      end else if (load_mem) begin
         ifid_instr   <= i_data;
         ifid_PC      <= PC;
         ifid_pred_PC <= pred_next_PC;
         ifid_valid   <= 1'b1;
         fetch_count  <= fetch_count + 1'b1;
      end else if (load_from_skid) begin
         ifid_instr   <= skid_instr;
         ifid_PC      <= skid_pc;
         ifid_pred_PC <= skid_pred_pc;
         ifid_valid   <= 1'b1;
         fetch_count  <= fetch_count + 1'b1;
      end else if (clear_valid) begin
         ifid_valid   <= 1'b0;
      end
   end

   ifid_skid_buffer #(
      .WIDTH (WORD_SIZE)
   ) u_skid (
      .clk          (clk),
      .reset_n      (reset_n),
      .load         (load_skid),
      .drop         (flush_act || load_from_skid),
      .load_instr   (i_data),
      .load_pc      (PC),
      .load_pred_pc (pred_next_PC),
      .instr        (skid_instr),
      .pc           (skid_pc),
      .pred_pc      (skid_pred_pc),
      .valid        (skid_valid)
   );

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard testbench for fetch_stage

module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] PC;
   logic [15:0] pred_next_PC;
   logic        flush;
   logic [15:0] flush_PC;
   logic        stall;
   logic        i_readM;
   logic [15:0] i_address;
   logic [15:0] i_data;
   logic        i_ready;
   logic [15:0] ifid_instr;
   logic [15:0] ifid_PC;
   logic [15:0] ifid_pred_PC;
   logic        ifid_valid;
   logic [15:0] fetch_count;

   int n_cmp  = 0;
   int n_fail = 0;
   int mem_wait;
   int wait_cnt;

   logic [47:0] exp_q[$];

   fetch_stage #(.WORD_SIZE(16), .RESET_PC(16'h0000)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .PC           (PC),
      .pred_next_PC (pred_next_PC),
      .flush        (flush),
      .flush_PC     (flush_PC),
      .stall        (stall),
      .i_readM      (i_readM),
      .i_address    (i_address),
      .i_data       (i_data),
      .i_ready      (i_ready),
      .ifid_instr   (ifid_instr),
      .ifid_PC      (ifid_PC),
      .ifid_pred_PC (ifid_pred_PC),
      .ifid_valid   (ifid_valid),
      .fetch_count  (fetch_count)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] instr_of(input logic [15:0] a);
      return a ^ 16'hBEEF;
   endfunction

   // Predictor model: sequential successor. Memory model: fixed word per address,
   // ready after mem_wait cycles of an outstanding request.
   assign pred_next_PC = PC + 16'd1;
   assign i_data       = instr_of(i_address);
   assign i_ready      = i_readM && (wait_cnt >= mem_wait);

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         wait_cnt <= 0;
      else if (i_readM && !i_ready)
         wait_cnt <= wait_cnt + 1;
      else
         wait_cnt <= 0;
   end

   task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic [15:0] p);
      exp_q.push_back({instr_of(p), p, p + 16'd1});
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Monitor: every IF/ID entry that decode actually takes is scored in order.
   always @(negedge clk) begin
      if (reset_n && ifid_valid && !stall && !flush) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL ifid_unexpected: got pc %h with empty expectation queue", ifid_PC);
         end else begin
            check("ifid_entry", {ifid_instr, ifid_PC, ifid_pred_PC}, exp_q.pop_front());
         end
      end
   end

   initial begin
      logic [15:0] pc;
      reset_n  = 1'b0;
      stall    = 1'b0;
      flush    = 1'b0;
      flush_PC = 16'h0000;
      mem_wait = 0;
      repeat (2) @(posedge clk);
      #2;
      check("rst_pc",      {32'd0, PC},          48'h0);
      check("rst_valid",   {47'd0, ifid_valid},  48'h0);
      check("rst_readm",   {47'd0, i_readM},     48'h0);
      check("rst_count",   {32'd0, fetch_count}, 48'h0);
      check("rst_ifid",    {ifid_instr, ifid_PC, ifid_pred_PC}, 48'h0);

      // Zero-wait streaming
      reset_n = 1'b1;
      for (int p = 0; p < 7; p++) push(16'(p));
      tick();                                       // IDLE -> FETCH
      check("first_readm", {47'd0, i_readM},   48'h1);
      check("first_addr",  {32'd0, i_address}, 48'h0);
      repeat (4) tick();
      check("count_after4", {32'd0, fetch_count}, 48'd4);
      repeat (2) tick();                            // IF/ID = PC 5, memory at 6
      check("pre_stall_pc", {32'd0, ifid_PC}, 48'd5);

      // Stall 3 cycles: one capture into the skid buffer, then no requests
      stall = 1'b1;
      tick();
      check("hold_readm0", {47'd0, i_readM}, 48'h0);
      check("hold_ifid5",  {32'd0, ifid_PC}, 48'd5);
      check("hold_pc7",    {32'd0, PC},      48'd7);
      tick();
      check("hold_readm1", {47'd0, i_readM}, 48'h0);
      tick();
      check("hold_readm2", {47'd0, i_readM}, 48'h0);
      stall = 1'b0;
      tick();                                       // skid -> IF/ID
      check("release_ifid6",  {32'd0, ifid_PC},   48'd6);
      check("release_readm",  {47'd0, i_readM},   48'h1);
      check("release_addr7",  {32'd0, i_address}, 48'd7);

      // Flush while in HOLD with stall asserted
      tick();                                       // IF/ID = 7
      stall = 1'b1;
      tick();                                       // skid = 8, HOLD
      check("hold2_readm", {47'd0, i_readM}, 48'h0);
      flush    = 1'b1;
      flush_PC = 16'h0040;
      tick();
      check("flush_valid", {47'd0, ifid_valid},  48'h0);
      check("flush_addr",  {32'd0, i_address},   48'h40);
      check("flush_readm", {47'd0, i_readM},     48'h1);
      check("flush_count", {32'd0, fetch_count}, 48'd8);
      flush    = 1'b0;
      stall    = 1'b0;
      mem_wait = 2;

      // Two wait states per fetch: valid 1 cycle in 3, PC steady while waiting
      push(16'h0040);
      push(16'h0041);
      for (int k = 1; k <= 8; k++) begin
         tick();
         check($sformatf("wait_valid_k%0d", k), {47'd0, ifid_valid}, {47'd0, (k % 3 == 0)});
         check($sformatf("wait_addr_k%0d", k),  {32'd0, i_address},  48'h40 + 48'(k / 3));
      end

      // Flush on the same edge the memory returns 0x42: word discarded
      flush    = 1'b1;
      flush_PC = 16'h0100;
      tick();
      check("flush_rdy_pc",    {32'd0, PC},          48'h100);
      check("flush_rdy_valid", {47'd0, ifid_valid},  48'h0);
      check("flush_rdy_count", {32'd0, fetch_count}, 48'd10);
      flush    = 1'b0;
      mem_wait = 0;

      // Stream until the load counter sits at 16'hFFFF, then wrap it
      pc = 16'h0100;
      for (int i = 0; i < 65525; i++) begin
         push(pc);
         pc = pc + 16'd1;
         tick();
      end
      check("count_ffff", {32'd0, fetch_count}, 48'hFFFF);
      tick();
      stall = 1'b1;                                 // this entry is never taken
      check("count_wrap", {32'd0, fetch_count}, 48'h0);
      tick();                                       // into HOLD
      check("hold3_readm", {47'd0, i_readM}, 48'h0);

      // Asynchronous reset mid-HOLD, checked before the next edge
      #1 reset_n = 1'b0;
      #1;
      check("async_pc",    {32'd0, PC},          48'h0);
      check("async_valid", {47'd0, ifid_valid},  48'h0);
      check("async_ifid",  {ifid_instr, ifid_PC, ifid_pred_PC}, 48'h0);
      check("async_count", {32'd0, fetch_count}, 48'h0);
      check("async_readm", {47'd0, i_readM},     48'h0);
      check("async_addr",  {32'd0, i_address},   48'h0);
      check("queue_drained", 48'(exp_q.size()), 48'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
